// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, oversampling constants and tick-divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
  localparam int DATA_BITS = 8;
  function automatic int tick_div(input int clock_freq, input int baud_rate);
    return clock_freq / (baud_rate * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider (clk, rst_n, restart holds count at 0 -> tick pulse every DIV clocks)
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV) > 0 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = !restart && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver (clk, rst_n, rx -> data_out, data_valid, frame_err, busy; UART_RX_PARITY_EN adds even parity and parity_err)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD_RATE);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_bit, perr_n, par_bad;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_s1, rx_s2, rx_s3, tick, fall, maj, at9, at15, s7, s8, load, valid_n, ferr_n;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .restart(state == IDLE), .tick(tick));
  assign fall = rx_s3 && !rx_s2;
  assign maj = (s7 && s8) || (s7 && rx_s2) || (s8 && rx_s2);
  assign at9 = tick && os_cnt == 4'(SAMPLE_C);
  assign at15 = tick && os_cnt == 4'(OVERSAMPLE - 1);
  assign busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  assign par_bad = ^shift_reg ^ par_bit;
`endif
  always_comb begin
    state_n = state;
    load = 1'b0;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: if (fall) state_n = START;
      START: state_n = (at9 && maj) ? IDLE : at15 ? DATA : START;
      DATA: if (at15 && bit_idx == 3'(DATA_BITS - 1)) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY: if (at15) state_n = STOP;
`endif
      STOP: if (at9) begin
        state_n = maj ? IDLE : WAIT_IDLE;
        load = maj;
        ferr_n = !maj;
`ifdef UART_RX_PARITY_EN
        perr_n = maj && par_bad;
        valid_n = maj && !par_bad;
`else
        valid_n = maj;
`endif
      end
      WAIT_IDLE: if (rx_s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {rx_s3, rx_s2, rx_s1} <= 3'b111;
      os_cnt <= '0;
      bit_idx <= '0;
      s7 <= 1'b0;
      s8 <= 1'b0;
      shift_reg <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
      os_cnt <= (state == IDLE) ? '0 : os_cnt + 4'(tick);
      bit_idx <= (state == IDLE) ? '0 : bit_idx + 3'(state == DATA && at15);
      s7 <= (tick && os_cnt == 4'(SAMPLE_A)) ? rx_s2 : s7;
      s8 <= (tick && os_cnt == 4'(SAMPLE_B)) ? rx_s2 : s8;
      shift_reg <= (state == DATA && at9) ? {maj, shift_reg[DATA_BITS-1:1]} : shift_reg;
      data_out <= load ? shift_reg : data_out;
      data_valid <= valid_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= (state == PARITY && at9) ? maj : par_bit;
      parity_err <= perr_n;
`endif
    end
endmodule
